merger_p: RTL and testbench

Parametrised two-input streaming merger for the sort tree: it merges two sorted streams of P-element tuples, each element W bits wide, into one sorted output stream of P-element tuples. It sits between two show-ahead input FIFOs and one output FIFO, as one node of the merge tree. It generalises the fixed 4×32 merger in two ways: P and W are parameters, and a per-tuple `last` flag delimits runs, so the held upper half is flushed and the block re-arms for the next run.

---
 rtl/merger_pkg.sv | 20 ++
 rtl/bitonic_merge_2p.sv | 45 ++++
 rtl/merger_p.sv | 113 +++++++++++
 tb/tb_merger_p.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/merger_pkg.sv
// Shared types and helpers for the sort-tree merger node.
package merger_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    MERGE = 2'd1,
    FLUSH = 2'd2
  } merger_state_t;

  // Ceiling log2, used to size the merge network depth.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitonic_merge_2p.sv
// Combinational bitonic merger: two ascending P-tuples in, one ascending 2P-tuple out.
module bitonic_merge_2p
  import merger_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned P = 4
) (
  input  logic [P*W-1:0]   a,
  input  logic [P*W-1:0]   b,
  output logic [2*P*W-1:0] y
);

  localparam int unsigned N      = 2 * P;
  localparam int unsigned STAGES = clog2(N);

  // a followed by reversed b forms a bitonic sequence; half-cleaners at distance P, P/2, ..., 1 sort it.
  function automatic logic [N*W-1:0] merge_net(input logic [P*W-1:0] lo_in,
                                               input logic [P*W-1:0] hi_in);
    logic [W-1:0] x [N];
    logic [W-1:0] t;
    logic [N*W-1:0] r;
    int d;
    for (int i = 0; i < int'(P); i++) begin
      x[i]              = lo_in[i*W +: W];
      x[int'(N) - 1 - i] = hi_in[i*W +: W];
    end
    for (int s = 0; s < int'(STAGES); s++) begin
      d = int'(P) >> s;
      for (int i = 0; i < int'(N); i++) begin
        if ((i & d) == 0) begin
          if (x[i] > x[i+d]) begin
            t      = x[i];
            x[i]   = x[i+d];
            x[i+d] = t;
          end
        end
      end
    end
    for (int i = 0; i < int'(N); i++) r[i*W +: W] = x[i];
    return r;
  endfunction

  always_comb y = merge_net(a, b);

endmodule

// File: rtl/merger_p.sv
// Two-input streaming merger node: merges two sorted runs of P-element tuples into one.
module merger_p
  import merger_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned P = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [P*W-1:0] i_fifo_1,
  input  logic           i_fifo_1_last,
  input  logic           i_fifo_1_empty,
  input  logic [P*W-1:0] i_fifo_2,
  input  logic           i_fifo_2_last,
  input  logic           i_fifo_2_empty,
  input  logic           i_fifo_out_ready,
  output logic           o_fifo_1_read,
  output logic           o_fifo_2_read,
  output logic           o_out_fifo_write,
  output logic [P*W-1:0] o_data,
  output logic           o_last
);

  localparam int unsigned TW = P * W;

  merger_state_t st_q;
  logic [TW-1:0] h_q;
  logic          d1_q;
  logic          d2_q;

  logic          sel2_c;
  logic          avail_c;
  logic          fill_fire_c;
  logic          merge_fire_c;
  logic [TW-1:0] t_c;
  logic          t_last_c;
  logic [2*TW-1:0] merged_c;

  // Source selection: smaller element 0 wins, ties go to input 1; a finished stream is never chosen.
  always_comb begin
    sel2_c       = 1'b0;
    avail_c      = 1'b0;
    fill_fire_c  = 1'b0;
    merge_fire_c = 1'b0;
    sel2_c = d1_q | (~d2_q & (i_fifo_2[W-1:0] < i_fifo_1[W-1:0]));
    if (d1_q | d2_q) avail_c = sel2_c ? ~i_fifo_2_empty : ~i_fifo_1_empty;
    else             avail_c = ~i_fifo_1_empty & ~i_fifo_2_empty;
    fill_fire_c  = (st_q == FILL) & ~i_fifo_1_empty & ~i_fifo_2_empty;
    merge_fire_c = (st_q == MERGE) & ~(d1_q & d2_q) & avail_c & i_fifo_out_ready;
  end

  assign t_c      = sel2_c ? i_fifo_2 : i_fifo_1;
  assign t_last_c = sel2_c ? i_fifo_2_last : i_fifo_1_last;

  assign o_fifo_1_read = ~i_rst & (fill_fire_c | merge_fire_c) & ~sel2_c;
  assign o_fifo_2_read = ~i_rst & (fill_fire_c | merge_fire_c) &  sel2_c;

  bitonic_merge_2p #(.W(W), .P(P)) u_net (
    .a (h_q),
    .b (t_c),
    .y (merged_c)
  );

  // FSM, held upper half and output register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q             <= FILL;
      h_q              <= '0;
      d1_q             <= 1'b0;
      d2_q             <= 1'b0;
      o_out_fifo_write <= 1'b0;
      o_data           <= '0;
      o_last           <= 1'b0;
    end else begin
      o_out_fifo_write <= 1'b0;
      case (st_q)
        FILL: begin
          if (fill_fire_c) begin
            h_q  <= t_c;
            d1_q <= ~sel2_c & t_last_c;
            d2_q <=  sel2_c & t_last_c;
            st_q <= MERGE;
          end
        end
        MERGE: begin
          if (d1_q & d2_q) begin
            st_q <= FLUSH;
          end else if (merge_fire_c) begin
            o_data           <= merged_c[TW-1:0];
            o_last           <= 1'b0;
            o_out_fifo_write <= 1'b1;
            h_q              <= merged_c[2*TW-1:TW];
            if (t_last_c & ~sel2_c) d1_q <= 1'b1;
            if (t_last_c &  sel2_c) d2_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (i_fifo_out_ready) begin
            o_data           <= h_q;
            o_last           <= 1'b1;
            o_out_fifo_write <= 1'b1;
            h_q              <= '0;
            d1_q             <= 1'b0;
            d2_q             <= 1'b0;
            st_q             <= FILL;
          end
        end
        default: st_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_merger_p.sv
// Directed bench for merger_p with show-ahead input FIFO models and an expected-output queue.
module tb_merger_p;

  localparam int unsigned W  = 32;
  localparam int unsigned P  = 4;
  localparam int unsigned TW = P * W;

  logic          clk;
  logic          rst;
  logic [TW-1:0] fifo_1;
  logic          fifo_1_last;
  logic          fifo_1_empty;
  logic [TW-1:0] fifo_2;
  logic          fifo_2_last;
  logic          fifo_2_empty;
  logic          out_ready;
  logic          fifo_1_read;
  logic          fifo_2_read;
  logic          out_write;
  logic [TW-1:0] data;
  logic          last;

  merger_p #(.W(W), .P(P)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fifo_1         (fifo_1),
    .i_fifo_1_last    (fifo_1_last),
    .i_fifo_1_empty   (fifo_1_empty),
    .i_fifo_2         (fifo_2),
    .i_fifo_2_last    (fifo_2_last),
    .i_fifo_2_empty   (fifo_2_empty),
    .i_fifo_out_ready (out_ready),
    .o_fifo_1_read    (fifo_1_read),
    .o_fifo_2_read    (fifo_2_read),
    .o_out_fifo_write (out_write),
    .o_data           (data),
    .o_last           (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [TW:0] q1[$];
  logic [TW:0] q2[$];
  logic [TW:0] expq[$];
  int n_checks;
  int n_fail;
  int nwrites;
  int cyc;
  int first_pop;
  int hold2;
  logic hold_req;
  int ready_mode;
  logic prev_ready;
  logic rd1;
  logic rd2;

  function automatic logic [TW:0] mk(input logic l, input logic [31:0] e0, e1, e2, e3);
    return {l, e3, e2, e1, e0};
  endfunction

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    fifo_1_empty = (q1.size() == 0);
    fifo_1       = fifo_1_empty ? '0 : q1[0][TW-1:0];
    fifo_1_last  = fifo_1_empty ? 1'b0 : q1[0][TW];
    fifo_2_empty = (q2.size() == 0) || (hold2 > 0);
    fifo_2       = fifo_2_empty ? '0 : q2[0][TW-1:0];
    fifo_2_last  = fifo_2_empty ? 1'b0 : q2[0][TW];
    if (ready_mode == 0 || first_pop == 0) out_ready = 1'b1;
    else out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endtask

  // One clock: sample at negedge, model the FIFO pops just after the posedge.
  task automatic cycle();
    logic [TW:0] e;
    @(negedge clk);
    rd1 = fifo_1_read;
    rd2 = fifo_2_read;
    if (out_write) begin
      nwrites++;
      check("wr_after_ready", TW'(prev_ready), TW'(1));
      if (expq.size() == 0) begin
        check("extra_write", TW'(1), TW'(0));
      end else begin
        e = expq.pop_front();
        check("data", data, e[TW-1:0]);
        check("last", TW'(last), TW'(e[TW]));
      end
    end
    if (rd1) check("underrun1", TW'(fifo_1_empty), TW'(0));
    if (rd2) check("underrun2", TW'(fifo_2_empty), TW'(0));
    if (first_pop != 0 && !out_ready) check("stall_pop", TW'({rd1, rd2}), TW'(0));
    if (hold2 > 0) check("hold_quiet", TW'({rd1, rd2, out_write}), TW'(0));
    prev_ready = out_ready;
    @(posedge clk);
    #1;
    if (hold2 > 0) hold2--;
    if (rd1) begin
      void'(q1.pop_front());
      if (first_pop == 0) first_pop = 1;
    end
    if (rd2) begin
      void'(q2.pop_front());
      if (first_pop == 0) first_pop = 2;
    end
    if (hold_req && first_pop != 0) begin
      hold2    = 10;
      hold_req = 1'b0;
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic start_run(input int mode);
    ready_mode = mode;
    first_pop  = 0;
    cyc        = 0;
    nwrites    = 0;
    prev_ready = 1'b1;
    drive_inputs();
  endtask

  task automatic finish_run(input int n_exp, input int budget);
    int k;
    k = 0;
    while (expq.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    check("timeout", TW'(expq.size()), TW'(0));
    for (int i = 0; i < 4; i++) cycle();
    check("write_count", TW'(nwrites), TW'(n_exp));
  endtask

  task automatic load_s1();
    q1.delete(); q2.delete(); expq.delete();
    q1.push_back(mk(0, 1, 3, 5, 7));
    q1.push_back(mk(0, 9, 11, 13, 15));
    q1.push_back(mk(1, 17, 19, 21, 23));
    q2.push_back(mk(0, 2, 4, 6, 8));
    q2.push_back(mk(0, 10, 12, 14, 16));
    q2.push_back(mk(1, 18, 20, 22, 24));
    expq.push_back(mk(0, 1, 2, 3, 4));
    expq.push_back(mk(0, 5, 6, 7, 8));
    expq.push_back(mk(0, 9, 10, 11, 12));
    expq.push_back(mk(0, 13, 14, 15, 16));
    expq.push_back(mk(0, 17, 18, 19, 20));
    expq.push_back(mk(1, 21, 22, 23, 24));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; nwrites = 0; cyc = 0; first_pop = 0;
    hold2 = 0; hold_req = 1'b0; ready_mode = 0; prev_ready = 1'b1;
    rd1 = 1'b0; rd2 = 1'b0;
    rst = 1'b1;
    load_s1();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write", TW'(out_write), TW'(0));
    check("rst_data", data, TW'(0));
    check("rst_last", TW'(last), TW'(0));
    check("rst_read1", TW'(fifo_1_read), TW'(0));
    check("rst_read2", TW'(fifo_2_read), TW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Interleaved runs, ready held high.
    start_run(0);
    finish_run(6, 200);

    // Same runs with ready toggling 1,0,0,1.
    load_s1();
    start_run(1);
    finish_run(6, 200);

    // Tie on all elements: input 1 goes first.
    q1.delete(); q2.delete(); expq.delete();
    q1.push_back(mk(1, 5, 5, 5, 5));
    q2.push_back(mk(1, 5, 5, 5, 5));
    expq.push_back(mk(0, 5, 5, 5, 5));
    expq.push_back(mk(1, 5, 5, 5, 5));
    start_run(0);
    finish_run(2, 100);
    check("tie_first_pop", TW'(first_pop), TW'(1));

    // Input 2 starved for 10 cycles after FILL.
    load_s1();
    hold_req = 1'b1;
    start_run(0);
    finish_run(6, 200);
    check("hold_first_pop", TW'(first_pop), TW'(1));

    // Two back-to-back single-tuple runs.
    q1.delete(); q2.delete(); expq.delete();
    q1.push_back(mk(1, 1, 2, 3, 4));
    q1.push_back(mk(1, 7, 7, 7, 7));
    q2.push_back(mk(1, 0, 9, 9, 9));
    q2.push_back(mk(1, 8, 8, 8, 8));
    expq.push_back(mk(0, 0, 1, 2, 3));
    expq.push_back(mk(1, 4, 9, 9, 9));
    expq.push_back(mk(0, 7, 7, 7, 7));
    expq.push_back(mk(1, 8, 8, 8, 8));
    start_run(0);
    finish_run(4, 200);
    check("b2b_first_pop", TW'(first_pop), TW'(2));

    // Reset mid-run after the second output.
    load_s1();
    start_run(0);
    for (int k = 0; k < 100 && nwrites < 2; k++) cycle();
    check("mid_two_writes", TW'(nwrites), TW'(2));
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_write", TW'(out_write), TW'(0));
    check("mid_rst_data", data, TW'(0));
    check("mid_rst_last", TW'(last), TW'(0));
    check("mid_rst_reads", TW'({fifo_1_read, fifo_2_read}), TW'(0));
    @(posedge clk);
    #1;
    q1.delete(); q2.delete(); expq.delete();
    drive_inputs();
    rst = 1'b0;
    load_s1();
    start_run(0);
    finish_run(6, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
